mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter MAX_DM_STREAK, default 4: max consecutive data-side grants while a fetch waits.
REQ-002 SHALL provide parameter ACK_TIMEOUT, default 255: max cycles waited for bus_ack before abort.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  fetch read request, held until if_ack.
REQ-006 if_addr  input  32  fetch word address.
REQ-007 if_data  output  32  fetched word, valid while if_ack high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 dm_r / dm_w  input  1 each  data-side read / write request, held until dm_ack.
REQ-010 dm_sz  input  2  access size, 0 byte, 1 half, 2 word; dm_addr input 32; dm_wdata input 32.
REQ-011 dm_rdata  output  32  raw read data, valid while dm_ack high; dm_ack output 1, one-cycle pulse.
REQ-012 bus_r, bus_w  output  1 each; bus_sz output 2; bus_addr output 32; bus_wdata output 32: shared memory port.
REQ-013 bus_rdata  input  32; bus_ack  input  1  memory completion, may arrive in the first strobe cycle.
REQ-014 bus_err  output  1  one-cycle pulse concurrent with the ack of an aborted transaction.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, DONE.
REQ-016 IDLE: no request -> stay; otherwise grant per REQ-019, latch addr/sz/wdata/kind into registers, go to BUSY_IF or BUSY_DM.
REQ-017 BUSY_*: bus_r/bus_w driven from latched registers (registered outputs, no combinational path from requester inputs); on bus_ack capture bus_rdata, go DONE.
REQ-018 DONE: assert the granted side's ack for exactly one cycle with captured data, all bus strobes low, then go IDLE.
REQ-019 Priority: data side wins, except when if_req is high and streak counter equals MAX_DM_STREAK, then fetch wins.
REQ-020 Streak counter: +1 on each data grant while if_req high; cleared on fetch grant or on data grant with if_req low; saturates at MAX_DM_STREAK.
REQ-021 Fetch grants SHALL drive bus_sz = 2, bus_r = 1, bus_w = 0.
REQ-022 dm_r and dm_w both high SHALL be treated as a write.
REQ-023 Minimum latency: request seen in IDLE cycle N -> strobe at N+1 -> if bus_ack at N+1, ack at N+2; one IDLE cycle between transactions.
REQ-024 Requesters deassert or change request at the edge ending their ack cycle; arbiter samples requests only in IDLE.
REQ-025 Timeout: cycle counter cleared on grant; if it reaches ACK_TIMEOUT in BUSY_*, go DONE with data 0, ack and bus_err pulsed.
REQ-026 Request changes while BUSY_* SHALL not affect bus outputs.
REQ-027 bus_ack outside BUSY_* SHALL be ignored.
REQ-028 Non-granted side's ack SHALL stay low in every state.

Reset
REQ-029 rst low SHALL immediately force state IDLE; all strobes, acks, bus_err low; streak/timeout counters 0; data/addr registers 0.
REQ-030 Reset asserted mid-transaction SHALL drop bus strobes asynchronously, with no ack for the aborted transaction.
REQ-031 First grant possible in the first cycle after rst deasserts.

Structure
REQ-032 State enum type and default MAX_DM_STREAK / ACK_TIMEOUT constants SHALL live in pipeline_pkg.
REQ-033 Single flat module; no sub-module needed (streak and timeout counters inline).

Verification
REQ-034 Fetch-only: if_req, if_addr 0x100; memory acks first strobe cycle with 0xDEADBEEF -> bus_r, bus_addr 0x100, bus_sz 2 at N+1; if_ack with if_data 0xDEADBEEF at N+2.
REQ-035 Simultaneous: if_req and dm_w (addr 0x2000, wdata 0x55, sz 0) in the same IDLE cycle -> data write first; fetch granted in the next IDLE.
REQ-036 Starvation: dm_r held continuously with if_req high -> exactly 4 data grants, then 1 fetch grant, repeating.
REQ-037 Timeout: dm_r granted, bus_ack never -> dm_ack and bus_err high together 256 cycles after grant, dm_rdata 0.
REQ-038 Reset mid-transaction: rst low during BUSY_DM with bus_w high -> bus_w low same cycle, no dm_ack; after release, a new fetch completes normally.
REQ-039 Late ack: bus_ack arrives 3 cycles after strobe with 0x12345678 -> bus strobes held stable 3 cycles, dm_rdata 0x12345678 with dm_ack next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared arbiter types and default tuning constants for the memory port.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam int DEF_MAX_DM_STREAK = 4;
    localparam int DEF_ACK_TIMEOUT   = 255;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one shared memory port.
// Latency: request in IDLE cycle N -> strobe N+1 -> ack N+2 at best; one IDLE cycle between transactions.
// Backpressure: requesters hold until their ack; a silent memory is aborted after ACK_TIMEOUT cycles.
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_ack,

    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [1:0]  dm_sz,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,

    output logic        bus_r,
    output logic        bus_w,
    output logic [1:0]  bus_sz,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    localparam int STREAK_W = cnt_width(MAX_DM_STREAK);
    localparam int TMO_W    = cnt_width(ACK_TIMEOUT);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
    // Abort on the cycle that would bring the wait count to ACK_TIMEOUT.
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

    arb_state_t          state_q;
    arb_state_t          state_n;
    logic [STREAK_W-1:0] streak_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [1:0]          sz_q;
    logic                bus_r_q;
    logic                bus_w_q;
    logic                if_ack_q;
    logic                dm_ack_q;
    logic                err_q;

    logic                dm_req;
    logic                busy;
    logic                grant_if;
    logic                grant_dm;
    logic                complete;
    logic                abort;

    assign dm_req = dm_r | dm_w;
    assign busy   = (state_q == BUSY_IF) || (state_q == BUSY_DM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                // Data side wins unless it has starved a waiting fetch long enough.
                if (if_req && (!dm_req || streak_q == STREAK_MAX)) begin
                    grant_if = 1'b1;
                    state_n  = BUSY_IF;
                end else if (dm_req) begin
                    grant_dm = 1'b1;
                    state_n  = BUSY_DM;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (bus_ack) begin
                    complete = 1'b1;
                    state_n  = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sz_q     <= '0;
            bus_r_q  <= 1'b0;
            bus_w_q  <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;

            if (grant_if) begin
                addr_q   <= if_addr;
                sz_q     <= SZ_WORD;
                wdata_q  <= '0;
                bus_r_q  <= 1'b1;
                bus_w_q  <= 1'b0;
                tmo_q    <= '0;
                streak_q <= '0;
            end

            if (grant_dm) begin
                addr_q  <= dm_addr;
                sz_q    <= dm_sz;
                wdata_q <= dm_wdata;
                // Read and write together resolve to a write.
                bus_r_q <= ~dm_w;
                bus_w_q <= dm_w;
                tmo_q   <= '0;
                if (!if_req) begin
                    streak_q <= '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + 1'b1;
                end
            end

            if (busy && !complete && !abort) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (complete || abort) begin
                rdata_q  <= complete ? bus_rdata : 32'd0;
                bus_r_q  <= 1'b0;
                bus_w_q  <= 1'b0;
                if_ack_q <= (state_q == BUSY_IF);
                dm_ack_q <= (state_q == BUSY_DM);
                err_q    <= abort;
            end
        end
    end

    assign bus_r     = bus_r_q;
    assign bus_w     = bus_w_q;
    assign bus_sz    = sz_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_data   = rdata_q;
    assign dm_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction vector table plus hand-written corner sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ack;
    logic        dm_r;
    logic        dm_w;
    logic [1:0]  dm_sz;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_r;
    logic        bus_w;
    logic [1:0]  bus_sz;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.MAX_DM_STREAK(4), .ACK_TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_ack    (if_ack),
        .dm_r      (dm_r),
        .dm_w      (dm_w),
        .dm_sz     (dm_sz),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .bus_r     (bus_r),
        .bus_w     (bus_w),
        .bus_sz    (bus_sz),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_fetch;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_r;
        logic        exp_w;
        logic [1:0]  exp_sz;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        @(negedge clk);
        if_req   = v.is_fetch;
        if_addr  = v.addr;
        dm_r     = v.rd;
        dm_w     = v.wr;
        dm_sz    = v.sz;
        dm_addr  = v.addr;
        dm_wdata = v.wdata;
        @(negedge clk);
        check($sformatf("v%0d_bus_r", idx), bus_r, v.exp_r);
        check($sformatf("v%0d_bus_w", idx), bus_w, v.exp_w);
        check($sformatf("v%0d_bus_sz", idx), bus_sz, v.exp_sz);
        check($sformatf("v%0d_bus_addr", idx), bus_addr, v.addr);
        if (v.exp_w) check($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.wdata);
        check($sformatf("v%0d_early_ack", idx), {if_ack, dm_ack}, 2'b00);
        for (int i = 0; i < v.delay; i++) begin
            // Requester inputs wander while busy; the bus must not follow them.
            dm_addr = ~v.addr;
            if_addr = ~v.addr;
            dm_sz   = ~v.sz;
            @(negedge clk);
            check($sformatf("v%0d_hold%0d", idx, i), {bus_r, bus_w, bus_sz, bus_addr},
                  {v.exp_r, v.exp_w, v.exp_sz, v.addr});
            check($sformatf("v%0d_hold%0d_ack", idx, i), {if_ack, dm_ack}, 2'b00);
        end
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
        check($sformatf("v%0d_acks", idx), {if_ack, dm_ack}, {v.is_fetch, !v.is_fetch});
        check($sformatf("v%0d_err", idx), bus_err, 1'b0);
        check($sformatf("v%0d_strobes_off", idx), {bus_r, bus_w}, 2'b00);
        if (!v.exp_w) begin
            if (v.is_fetch) check($sformatf("v%0d_if_data", idx), if_data, v.exp_data);
            else            check($sformatf("v%0d_dm_rdata", idx), dm_rdata, v.exp_data);
        end
        if_req = 1'b0;
        dm_r   = 1'b0;
        dm_w   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        logic exp_fetch;
        int   w;

        //          fetch rd   wr   sz     addr           wdata          dly rdata          r    w    sz     data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0000_0011, 0, 32'h0000_BEEF, 1'b1, 1'b0, 2'd1, 32'h0000_BEEF};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_2000, 32'h0000_0055, 1, 32'h0,         1'b0, 1'b1, 2'd0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_3000, 32'hCAFE_F00D, 0, 32'h0,         1'b0, 1'b1, 2'd2, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0,         3, 32'h1234_5678, 1'b1, 1'b0, 2'd2, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0104, 32'h0,         2, 32'h0BAD_F00D, 1'b1, 1'b0, 2'd2, 32'h0BAD_F00D};

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_r = 1'b0; dm_w = 1'b0; dm_sz = '0; dm_addr = '0; dm_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_strobes", {bus_r, bus_w}, 2'b00);
        check("rst_acks", {if_ack, dm_ack, bus_err}, 3'b000);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_data", if_data, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // Simultaneous fetch and data write: write first, fetch in the next IDLE.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        dm_w = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h55; dm_sz = 2'd0;
        @(negedge clk);
        check("simul_first", {bus_r, bus_w, bus_sz, bus_addr}, {1'b0, 1'b1, 2'd0, 32'h2000});
        check("simul_wdata", bus_wdata, 32'h55);
        bus_ack = 1'b1; bus_rdata = 32'h0;
        @(negedge clk);
        bus_ack = 1'b0;
        check("simul_dm_ack", {if_ack, dm_ack}, 2'b01);
        dm_w = 1'b0;
        @(negedge clk);
        check("simul_idle_gap", {bus_r, bus_w}, 2'b00);
        @(negedge clk);
        check("simul_fetch", {bus_r, bus_w, bus_sz, bus_addr}, {1'b1, 1'b0, 2'd2, 32'h100});
        bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus_ack = 1'b0;
        check("simul_if_ack", {if_ack, dm_ack}, 2'b10);
        check("simul_if_data", if_data, 32'hA5A5_A5A5);
        if_req = 1'b0;

        // Starvation: both held, expect four data grants then one fetch, repeating.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h600;
        dm_r = 1'b1; dm_w = 1'b0; dm_addr = 32'h5000; dm_sz = 2'd2;
        for (int t = 0; t < 10; t++) begin
            w = 0;
            @(negedge clk);
            while (!bus_r && w < 4) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("starve%0d_strobe", t), bus_r, 1'b1);
            exp_fetch = (t % 5 == 4);
            check($sformatf("starve%0d_grant", t), bus_addr, exp_fetch ? 32'h600 : 32'h5000);
            bus_ack = 1'b1; bus_rdata = 32'hA000_0000 + 32'(t);
            @(negedge clk);
            bus_ack = 1'b0;
            check($sformatf("starve%0d_ack", t), {if_ack, dm_ack}, exp_fetch ? 2'b10 : 2'b01);
        end
        if_req = 1'b0; dm_r = 1'b0;

        // bus_ack while idle must be ignored.
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        repeat (2) begin
            @(negedge clk);
            check("stray_ack", {if_ack, dm_ack, bus_err, bus_r, bus_w}, 5'b0);
        end
        bus_ack = 1'b0;
        check("stray_data", if_data, 32'hA000_0009);

        // Timeout: memory never answers a data read.
        @(negedge clk);
        dm_r = 1'b1; dm_addr = 32'h7000; dm_sz = 2'd2;
        ok = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (!(bus_r === 1'b1 && dm_ack === 1'b0 && bus_err === 1'b0)) ok = 1'b0;
        end
        check("tmo_wait", ok, 1'b1);
        @(negedge clk);
        check("tmo_ack_err", {dm_ack, bus_err, if_ack}, 3'b110);
        check("tmo_rdata", dm_rdata, 32'h0);
        check("tmo_strobe", bus_r, 1'b0);
        dm_r = 1'b0;
        @(negedge clk);
        check("tmo_pulse_end", {dm_ack, bus_err}, 2'b00);

        // Reset mid-write, then a fetch granted right after release.
        @(negedge clk);
        dm_w = 1'b1; dm_addr = 32'h8000; dm_wdata = 32'h77; dm_sz = 2'd2;
        @(negedge clk);
        check("rstmid_busy", bus_w, 1'b1);
        #2 rst = 1'b0;
        #1 check("rstmid_async", {bus_r, bus_w}, 2'b00);
        dm_w = 1'b0;
        if_req = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        check("rstmid_no_ack", {dm_ack, if_ack, bus_err, bus_w}, 4'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstrel_grant", {bus_r, bus_w, bus_sz, bus_addr}, {1'b1, 1'b0, 2'd2, 32'h200});
        bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus_ack = 1'b0;
        check("rstrel_ack", {if_ack, dm_ack}, 2'b10);
        check("rstrel_data", if_data, 32'h1357_9BDF);
        if_req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
